// File: rtl/stoplight_phase_sched.sv
// Demand-actuated four-way phase scheduler: green -> yellow -> all-red -> next green.
// Optional emergency preemption (port + PREEMPT_HOLD state) is built when PREEMPT_EN is defined.
module stoplight_phase_sched #(
  parameter int MIN_GREEN  = 10,
  parameter int MAX_GREEN  = 40,
  parameter int YELLOW_CYC = 4,
  parameter int CLEAR_CYC  = 2,
  parameter int TMR_W      = 8
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       n_car,
  input  logic       s_car,
  input  logic       e_car,
  input  logic       w_car,
  input  logic       n_carL,
  input  logic       s_carL,
  input  logic       e_carL,
  input  logic       w_carL,
`ifdef PREEMPT_EN
  input  logic       preempt,
`endif
  output logic [4:0] state1,
  output logic [1:0] cur_phase,
  output logic       phase_done
);

`ifdef PREEMPT_EN
  typedef enum logic [1:0] {ST_GREEN, ST_YELLOW, ST_ALLRED, ST_PREEMPT_HOLD} state_t;
`else
  typedef enum logic [1:0] {ST_GREEN, ST_YELLOW, ST_ALLRED} state_t;
`endif

  localparam logic [4:0] CODE_NS     = 5'b00000;
  localparam logic [4:0] CODE_NS_Y   = 5'b00010;
  localparam logic [4:0] CODE_NSL    = 5'b01100;
  localparam logic [4:0] CODE_NSL_Y  = 5'b01101;
  localparam logic [4:0] CODE_EW     = 5'b00001;
  localparam logic [4:0] CODE_EW_Y   = 5'b00011;
  localparam logic [4:0] CODE_EWL    = 5'b01110;
  localparam logic [4:0] CODE_EWL_Y  = 5'b01111;
  localparam logic [4:0] CODE_ALLRED = 5'b10000;

  localparam logic [TMR_W-1:0] MIN_LAST = TMR_W'(MIN_GREEN - 1);
  localparam logic [TMR_W-1:0] MAX_LAST = TMR_W'(MAX_GREEN - 1);
  localparam logic [TMR_W-1:0] Y_LAST   = TMR_W'(YELLOW_CYC - 1);
  localparam logic [TMR_W-1:0] CLR_LAST = TMR_W'(CLEAR_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = 1;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [1:0]       phase_d;
  logic [4:0]       state1_d;
  logic             pdone_d;
  logic [3:0]       demand;
  logic             conflict;
  logic             own_demand;

  function automatic logic [4:0] green_code(input logic [1:0] ph);
    case (ph)
      2'd0:    green_code = CODE_NS;
      2'd1:    green_code = CODE_NSL;
      2'd2:    green_code = CODE_EW;
      default: green_code = CODE_EWL;
    endcase
  endfunction

  function automatic logic [4:0] yellow_code(input logic [1:0] ph);
    case (ph)
      2'd0:    yellow_code = CODE_NS_Y;
      2'd1:    yellow_code = CODE_NSL_Y;
      2'd2:    yellow_code = CODE_EW_Y;
      default: yellow_code = CODE_EWL_Y;
    endcase
  endfunction

  // Walk the ring from the farthest offset back to the nearest so the nearest demanded
  // phase after cur wins; with no demand anywhere the current phase is re-entered.
  function automatic logic [1:0] pick_next(input logic [1:0] cur, input logic [3:0] dem);
    logic [1:0] p;
    pick_next = cur;
    for (int i = 3; i >= 1; i--) begin
      p = cur + 2'(i);
      if (dem[p]) pick_next = p;
    end
  endfunction

  assign demand     = {e_carL | w_carL, e_car | w_car, n_carL | s_carL, n_car | s_car};
  assign own_demand = demand[cur_phase];
  assign conflict   = |(demand & ~(4'b0001 << cur_phase));

  always_comb begin
    state_d = state_q;
    phase_d = cur_phase;
    pdone_d = 1'b0;
    case (state_q)
      ST_GREEN: begin
`ifdef PREEMPT_EN
        if (preempt) begin
          state_d = ST_YELLOW;
          pdone_d = 1'b1;
        end else
`endif
        if (tmr_q >= MIN_LAST && conflict && (!own_demand || tmr_q == MAX_LAST)) begin
          state_d = ST_YELLOW;
          pdone_d = 1'b1;
        end
      end
      ST_YELLOW: begin
        if (tmr_q == Y_LAST) begin
          state_d = ST_ALLRED;
`ifdef PREEMPT_EN
          if (preempt) state_d = ST_PREEMPT_HOLD;
`endif
        end
      end
      ST_ALLRED: begin
`ifdef PREEMPT_EN
        if (preempt) begin
          state_d = ST_PREEMPT_HOLD;
        end else
`endif
        if (tmr_q == CLR_LAST) begin
          state_d = ST_GREEN;
          phase_d = pick_next(cur_phase, demand);
        end
      end
`ifdef PREEMPT_EN
      ST_PREEMPT_HOLD: begin
        if (!preempt) state_d = ST_ALLRED;
      end
`endif
      default: state_d = ST_ALLRED;
    endcase

    if (state_d != state_q)  tmr_d = '0;
    else if (tmr_q == MAX_LAST) tmr_d = tmr_q;
    else                     tmr_d = tmr_q + TMR_ONE;

    case (state_d)
      ST_GREEN:  state1_d = green_code(phase_d);
      ST_YELLOW: state1_d = yellow_code(phase_d);
      default:   state1_d = CODE_ALLRED;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q    <= ST_ALLRED;
      tmr_q      <= '0;
      cur_phase  <= 2'd3;
      state1     <= CODE_ALLRED;
      phase_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      cur_phase  <= phase_d;
      state1     <= state1_d;
      phase_done <= pdone_d;
    end
  end

endmodule

// File: tb/tb_stoplight_phase_sched.sv
// Directed bench for stoplight_phase_sched (MIN_GREEN=4, MAX_GREEN=8, YELLOW_CYC=3, CLEAR_CYC=2).
// Demand byte: bit0 n_car, 1 s_car, 2 e_car, 3 w_car, 4 n_carL, 5 s_carL, 6 e_carL, 7 w_carL.
module tb_stoplight_phase_sched;

  typedef struct {
    logic       rst;
    logic [7:0] dem;
    logic       pre;
    logic [4:0] s1;
    logic       pd;
    logic [1:0] cur;
  } vec_t;

  logic       CLK = 1'b0;
  logic       rst;
  logic [7:0] dem;
  logic       preempt;
  logic [4:0] state1;
  logic [1:0] cur_phase;
  logic       phase_done;

  int total = 0;
  int bad   = 0;
  vec_t tbl[$];

  always #5 CLK = ~CLK;

  stoplight_phase_sched #(
    .MIN_GREEN(4), .MAX_GREEN(8), .YELLOW_CYC(3), .CLEAR_CYC(2), .TMR_W(8)
  ) dut (
    .CLK(CLK),
    .rst(rst),
    .n_car(dem[0]),
    .s_car(dem[1]),
    .e_car(dem[2]),
    .w_car(dem[3]),
    .n_carL(dem[4]),
    .s_carL(dem[5]),
    .e_carL(dem[6]),
    .w_carL(dem[7]),
`ifdef PREEMPT_EN
    .preempt(preempt),
`endif
    .state1(state1),
    .cur_phase(cur_phase),
    .phase_done(phase_done)
  );

  task automatic add(input int n, input logic r, input logic [7:0] d, input logic [4:0] s,
                     input logic p, input logic [1:0] c);
    for (int i = 0; i < n; i++) tbl.push_back('{rst: r, dem: d, pre: 1'b0, s1: s, pd: p, cur: c});
  endtask

  task automatic cyc(input string name, input logic r, input logic [7:0] d, input logic pr,
                     input logic [4:0] s, input logic p, input logic [1:0] c);
    rst     = r;
    dem     = d;
    preempt = pr;
    @(posedge CLK);
    #1;
    total++;
    if (state1 !== s || phase_done !== p || cur_phase !== c) begin
      bad++;
      $display("FAIL %s: got state1=%b phase_done=%b cur_phase=%0d, want state1=%b phase_done=%b cur_phase=%0d",
               name, state1, phase_done, cur_phase, s, p, c);
    end
  endtask

  initial begin
    rst = 1'b1;
    dem = 8'h00;
    preempt = 1'b0;

    // reset and first NS green
    add(2, 1, 8'h00, 5'b10000, 0, 3);
    add(1, 0, 8'h01, 5'b10000, 0, 3);
    add(1, 0, 8'h01, 5'b00000, 0, 0);
    // NS held to max green by own demand, then EW
    add(7, 0, 8'h05, 5'b00000, 0, 0);
    add(1, 0, 8'h05, 5'b00010, 1, 0);
    add(2, 0, 8'h05, 5'b00010, 0, 0);
    add(2, 0, 8'h05, 5'b10000, 0, 0);
    add(1, 0, 8'h05, 5'b00001, 0, 2);
    // min green exit, NSL and EW skipped, EWL rests with no conflict
    add(1, 1, 8'h00, 5'b10000, 0, 3);
    add(1, 0, 8'h01, 5'b10000, 0, 3);
    add(1, 0, 8'h01, 5'b00000, 0, 0);
    add(3, 0, 8'h40, 5'b00000, 0, 0);
    add(1, 0, 8'h40, 5'b00010, 1, 0);
    add(2, 0, 8'h40, 5'b00010, 0, 0);
    add(2, 0, 8'h40, 5'b10000, 0, 0);
    add(4, 0, 8'h40, 5'b01110, 0, 3);

    foreach (tbl[i]) cyc($sformatf("vec%0d", i), tbl[i].rst, tbl[i].dem, tbl[i].pre,
                         tbl[i].s1, tbl[i].pd, tbl[i].cur);

    // no demand at all: NS rests for 100 cycles, no phase_done
    cyc("idle_rst", 1, 8'h00, 0, 5'b10000, 0, 3);
    cyc("idle_clr", 0, 8'h01, 0, 5'b10000, 0, 3);
    cyc("idle_ns",  0, 8'h01, 0, 5'b00000, 0, 0);
    for (int i = 0; i < 100; i++) cyc("idle_hold", 0, 8'h00, 0, 5'b00000, 0, 0);

    // reset during second yellow cycle
    cyc("ry_rst",  1, 8'h00, 0, 5'b10000, 0, 3);
    cyc("ry_clr",  0, 8'h01, 0, 5'b10000, 0, 3);
    cyc("ry_ns0",  0, 8'h01, 0, 5'b00000, 0, 0);
    for (int i = 0; i < 3; i++) cyc("ry_ns", 0, 8'h04, 0, 5'b00000, 0, 0);
    cyc("ry_y1",   0, 8'h04, 0, 5'b00010, 1, 0);
    cyc("ry_y2",   0, 8'h04, 0, 5'b00010, 0, 0);
    cyc("ry_hit",  1, 8'h04, 0, 5'b10000, 0, 3);
    cyc("ry_clr2", 0, 8'h04, 0, 5'b10000, 0, 3);
    cyc("ry_ew",   0, 8'h04, 0, 5'b00001, 0, 2);

`ifdef PREEMPT_EN
    // preemption from EW green at tmr=1, held 10 cycles, NS waiting
    cyc("pe_rst", 1, 8'h00, 0, 5'b10000, 0, 3);
    cyc("pe_clr", 0, 8'h04, 0, 5'b10000, 0, 3);
    cyc("pe_ew0", 0, 8'h04, 0, 5'b00001, 0, 2);
    cyc("pe_ew1", 0, 8'h05, 0, 5'b00001, 0, 2);
    cyc("pe_y1",  0, 8'h05, 1, 5'b00011, 1, 2);
    cyc("pe_y",   0, 8'h05, 1, 5'b00011, 0, 2);
    cyc("pe_y",   0, 8'h05, 1, 5'b00011, 0, 2);
    for (int i = 0; i < 7; i++) cyc("pe_hold", 0, 8'h05, 1, 5'b10000, 0, 2);
    cyc("pe_rel1", 0, 8'h05, 0, 5'b10000, 0, 2);
    cyc("pe_rel2", 0, 8'h05, 0, 5'b10000, 0, 2);
    cyc("pe_ns",   0, 8'h05, 0, 5'b00000, 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
